// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl_if
// Brief    : Button inputs and time-control outputs of time_set_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if #(
  parameter int NUM_FIELDS = 3
);
  logic                  btn_mode;
  logic                  btn_up;
  logic                  btn_down;
  logic                  en_s;
  logic                  up;
  logic                  down;
  logic                  set_mode;
  logic [NUM_FIELDS-1:0] field_sel;

  modport master (
    input  btn_mode, btn_up, btn_down,
    output en_s, up, down, set_mode, field_sel
  );

  modport slave (
    output btn_mode, btn_up, btn_down,
    input  en_s, up, down, set_mode, field_sel
  );
endinterface
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Brief    : 1 Hz enable, button debounce, RUN/SET mode FSM and auto-repeat
//            adjust pulses for the century clock front end.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int NUM_FIELDS   = 3
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  time_set_ctrl_if.master bus
);
  localparam int c_PW      = $clog2(TICK_DIV);
  localparam int c_DW      = $clog2(DEBOUNCE_CYC + 1);
  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_RW      = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;
  localparam int c_IW      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  localparam logic [c_PW-1:0]       c_PRESC_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_PW-1:0]       c_PRESC_PRE  = c_PW'(TICK_DIV - 2);
  localparam logic [c_DW-1:0]       c_DEB_LAST   = c_DW'(DEBOUNCE_CYC - 1);
  localparam logic [c_RW-1:0]       c_DELAY_LOAD = c_RW'(REPEAT_DELAY - 1);
  localparam logic [c_RW-1:0]       c_RATE_LOAD  = c_RW'(REPEAT_RATE - 1);
  localparam logic [c_IW-1:0]       c_IDX_LAST   = c_IW'(NUM_FIELDS - 1);
  localparam logic [NUM_FIELDS-1:0] c_SEL_FIRST  = NUM_FIELDS'(1);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  // Bit order everywhere: [0] mode, [1] up, [2] down
  logic [2:0] w_btn_raw;
  logic [2:0] w_stable;
  assign w_btn_raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [c_DW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_btn_raw[gi];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + c_DW'(1);
        end
      end
    end

    assign w_stable[gi] = r_level;
  end

  logic [2:0]            r_stable_q;
  state_t                r_state;
  logic [c_IW-1:0]       r_field;
  logic [c_PW-1:0]       r_presc;
  logic                  r_up_act;
  logic                  r_dn_act;
  logic [c_RW-1:0]       r_up_cnt;
  logic [c_RW-1:0]       r_dn_cnt;
  logic                  r_en_s;
  logic                  r_up;
  logic                  r_down;
  logic                  r_set_mode;
  logic [NUM_FIELDS-1:0] r_field_sel;

  logic w_mode_ev;
  logic w_up_ev;
  logic w_dn_ev;
  assign w_mode_ev = w_stable[0] & ~r_stable_q[0];
  assign w_up_ev   = w_stable[1] & ~r_stable_q[1];
  assign w_dn_ev   = w_stable[2] & ~r_stable_q[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stable_q  <= '0;
      r_state     <= ST_RUN;
      r_field     <= '0;
      r_presc     <= '0;
      r_up_act    <= 1'b0;
      r_dn_act    <= 1'b0;
      r_up_cnt    <= '0;
      r_dn_cnt    <= '0;
      r_en_s      <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_set_mode  <= 1'b0;
      r_field_sel <= '0;
    end else begin
      r_stable_q <= w_stable;
      r_en_s     <= 1'b0;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_up_act <= 1'b0;
          r_dn_act <= 1'b0;
          r_up_cnt <= '0;
          r_dn_cnt <= '0;
          if (w_mode_ev) begin
            r_state     <= ST_SET;
            r_field     <= '0;
            r_presc     <= '0;
            r_set_mode  <= 1'b1;
            r_field_sel <= c_SEL_FIRST;
          end else begin
            r_presc <= (r_presc == c_PRESC_LAST) ? '0 : r_presc + c_PW'(1);
            r_en_s  <= (r_presc == c_PRESC_PRE);
          end
        end
        default: begin
          r_presc <= '0;
          if (w_mode_ev) begin
            // Field change cancels any pending adjust; held buttons must be re-pressed
            r_up_act <= 1'b0;
            r_dn_act <= 1'b0;
            r_up_cnt <= '0;
            r_dn_cnt <= '0;
            if (r_field == c_IDX_LAST) begin
              r_state     <= ST_RUN;
              r_field     <= '0;
              r_set_mode  <= 1'b0;
              r_field_sel <= '0;
            end else begin
              r_field     <= r_field + c_IW'(1);
              r_field_sel <= r_field_sel << 1;
            end
          end else begin
            if (w_up_ev && !w_stable[2]) begin
              r_up     <= 1'b1;
              r_up_act <= 1'b1;
              r_up_cnt <= c_DELAY_LOAD;
            end else if (r_up_act && w_stable[1] && !w_stable[2]) begin
              if (r_up_cnt == '0) begin
                r_up     <= 1'b1;
                r_up_cnt <= c_RATE_LOAD;
              end else begin
                r_up_cnt <= r_up_cnt - c_RW'(1);
              end
            end else begin
              r_up_act <= 1'b0;
              r_up_cnt <= '0;
            end

            if (w_dn_ev && !w_stable[1]) begin
              r_down   <= 1'b1;
              r_dn_act <= 1'b1;
              r_dn_cnt <= c_DELAY_LOAD;
            end else if (r_dn_act && w_stable[2] && !w_stable[1]) begin
              if (r_dn_cnt == '0) begin
                r_down   <= 1'b1;
                r_dn_cnt <= c_RATE_LOAD;
              end else begin
                r_dn_cnt <= r_dn_cnt - c_RW'(1);
              end
            end else begin
              r_dn_act <= 1'b0;
              r_dn_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.en_s      = r_en_s;
  assign bus.up        = r_up;
  assign bus.down      = r_down;
  assign bus.set_mode  = r_set_mode;
  assign bus.field_sel = r_field_sel;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_ctrl
// Brief    : Directed-vector bench for time_set_ctrl with hand-derived outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;
  localparam int c_TICK_DIV     = 10;
  localparam int c_DEBOUNCE_CYC = 4;
  localparam int c_REPEAT_DELAY = 20;
  localparam int c_REPEAT_RATE  = 5;
  localparam int c_NUM_FIELDS   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  time_set_ctrl_if #(.NUM_FIELDS(c_NUM_FIELDS)) bus ();

  time_set_ctrl #(
    .TICK_DIV    (c_TICK_DIV),
    .DEBOUNCE_CYC(c_DEBOUNCE_CYC),
    .REPEAT_DELAY(c_REPEAT_DELAY),
    .REPEAT_RATE (c_REPEAT_RATE),
    .NUM_FIELDS  (c_NUM_FIELDS)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.en_s, bus.up, bus.down, bus.set_mode, bus.field_sel};
  endfunction

  function automatic bit in_rng(input int k, input int a, input int b);
    return (k >= a) && (k < b);
  endfunction

  // Returns {rst_n, btn_mode, btn_up, btn_down} driven during cycle k
  function automatic logic [3:0] stim(input int scn, input int k);
    logic r = 1'b1;
    logic m = 1'b0;
    logic u = 1'b0;
    logic d = 1'b0;
    case (scn)
      2: m = in_rng(k, 3, 15) || in_rng(k, 25, 33) || in_rng(k, 43, 51) || in_rng(k, 61, 69);
      3: begin
        m = in_rng(k, 0, 8);
        u = in_rng(k, 16, 19) || in_rng(k, 30, 70);
      end
      4: begin
        m = in_rng(k, 0, 8);
        u = in_rng(k, 16, 26) || in_rng(k, 70, 110);
        d = in_rng(k, 16, 26) || in_rng(k, 40, 110);
      end
      5: begin
        m = in_rng(k, 0, 8) || in_rng(k, 20, 28);
        u = in_rng(k, 20, 60);
      end
      6: begin
        m = in_rng(k, 0, 8) || in_rng(k, 20, 28);
        u = (k >= 35);
        r = (k != 64);
      end
      default: ;
    endcase
    return {r, m, u, d};
  endfunction

  // Returns {en_s, up, down, set_mode, field_sel} expected in cycle k
  function automatic logic [6:0] expect_out(input int scn, input int k);
    logic       en = 1'b0;
    logic       u  = 1'b0;
    logic       d  = 1'b0;
    logic [2:0] fs = 3'b000;
    case (scn)
      1: en = (k == 9) || (k == 19) || (k == 29);
      2: begin
        fs = (k < 10) ? 3'b000 : (k < 32) ? 3'b001 : (k < 50) ? 3'b010 :
             (k < 68) ? 3'b100 : 3'b000;
        en = (k == 9) || (k == 77) || (k == 87);
      end
      3: begin
        fs = (k < 7) ? 3'b000 : 3'b001;
        u  = (k == 37) || (k == 57) || (k == 62) || (k == 67) || (k == 72);
      end
      4: begin
        fs = (k < 7) ? 3'b000 : 3'b001;
        d  = (k == 47) || (k == 67) || (k == 72);
      end
      5: fs = (k < 7) ? 3'b000 : (k < 27) ? 3'b001 : 3'b010;
      6: begin
        fs = (k < 7) ? 3'b000 : (k < 27) ? 3'b001 : (k < 65) ? 3'b010 : 3'b000;
        u  = (k == 42) || (k == 62);
        en = (k == 74) || (k == 84) || (k == 94);
      end
      default: ;
    endcase
    return {en, u, d, (fs != 3'b000), fs};
  endfunction

  task automatic run_scn(input int scn, input int ncyc);
    logic [3:0] s;
    rst_n        = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (3) tick();
    check_eq($sformatf("s%0d reset", scn), outs(), 7'b0);
    for (int k = 0; k < ncyc; k++) begin
      s            = stim(scn, k);
      rst_n        = s[3];
      bus.btn_mode = s[2];
      bus.btn_up   = s[1];
      bus.btn_down = s[0];
      check_eq($sformatf("s%0d cyc%0d {en,up,dn,set,sel}", scn, k), outs(), expect_out(scn, k));
      tick();
    end
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    run_scn(1, 35);   // free run prescaler
    run_scn(2, 90);   // mode cycling through all fields and back to RUN
    run_scn(3, 100);  // glitch rejection and auto-repeat on up
    run_scn(4, 130);  // simultaneous buttons, down repeat cut off by up
    run_scn(5, 70);   // mode and up coincident, held up across field change
    run_scn(6, 100);  // reset mid-repeat, then up ignored in RUN
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-end control stage of the century clock, directly upstream of the seconds counter and the rest of the time-field chain. It generates the 1 Hz count enable `en_s` from the system clock. It debounces three raw push-buttons (mode, up, down) and runs the RUN/SET mode state machine. In set mode it emits single-cycle, auto-repeating `up`/`down` adjust pulses together with a one-hot field select that each counter stage ANDs with `up`/`down`.

## Interface
- `TICK_DIV`, 50_000_000, clk cycles per `en_s` pulse (≥2)
- `DEBOUNCE_CYC`, 500_000, cycles a synchronized button level must be stable to be accepted (≥1)
- `REPEAT_DELAY`, 25_000_000, hold cycles from the first adjust pulse to the first repeat (≥1)
- `REPEAT_RATE`, 5_000_000, cycles between repeat pulses (≥1)
- `NUM_FIELDS`, 3, number of settable fields; index 0 = seconds
- `clk` in 1: single clock domain
- `rst_n` in 1: reset is synchronous and active-low
- `btn_mode` in 1: raw mode button, active-high, asynchronous
- `btn_up` in 1: raw up button, active-high, asynchronous
- `btn_down` in 1: raw down button, active-high, asynchronous
- `en_s` out 1: 1-cycle count enable, once per `TICK_DIV` cycles, RUN only
- `up` out 1: 1-cycle increment pulse, SET only
- `down` out 1: 1-cycle decrement pulse, SET only
- `set_mode` out 1: high in any SET state
- `field_sel` out NUM_FIELDS: one-hot field being set; all zero in RUN

## Operation
- Reset (`rst_n` low at a clk edge) sets all outputs to 0 and state to RUN. It clears the prescaler, the debounce and repeat counters, the synchronizers and the debounced levels. It overrides everything, including a reset arriving mid-debounce or mid-repeat.
- Synchronizer: each button passes through 2 flops.
- Debounce: per button, a counter of width `$clog2(DEBOUNCE_CYC+1)` increments while the synced level differs from the stable level and clears when they match. At `DEBOUNCE_CYC` consecutive differing cycles the stable level takes the synced value and the counter clears. Glitches shorter than `DEBOUNCE_CYC` are ignored.
- A press event is the registered rising edge of a stable level. A button held through reset produces a press once debounced after reset.
- State machine: RUN → SET(0) → SET(1) → … → SET(NUM_FIELDS-1) → RUN, advancing one step per mode press event.
  - `field_sel` = 1 << index in SET(index).
  - `set_mode` = 1 in every SET state.
- Prescaler: width `$clog2(TICK_DIV)`, counts 0..TICK_DIV-1 and wraps, running in RUN only.
  - `en_s` is high in the cycle the count equals TICK_DIV-1.
  - In SET the prescaler holds at 0 and `en_s` stays 0.
  - On SET→RUN the prescaler restarts at 0.
- Adjust (SET only), for up (down is symmetric):
  - A press event with stable down = 0 gives one `up` pulse and starts the repeat counter.
  - While stable up stays 1 and stable down stays 0, repeat pulses fire after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
  - Release, or the other button becoming stable-high, stops repeats and clears the counter.
- Both stable-high gives no pulses; `up` and `down` are never high together.
- A mode press event in the same cycle as an adjust pulse: the mode transition wins, the adjust pulse is suppressed and the repeat counters clear.
- A held adjust button carried over a field change does not repeat until it is re-pressed.
- Adjust buttons are ignored in RUN: no pulses, and the repeat counters are held clear.

## Timing
- Raw edge to stable level change: 2 + DEBOUNCE_CYC cycles. The event-derived output follows 1 cycle later, so raw press to `up`/`down`/state change = DEBOUNCE_CYC + 3 cycles.
- The first `en_s` after reset release, or after re-entering RUN, is in cycle TICK_DIV-1 (cycle 0 = first cycle in RUN). Period is exactly TICK_DIV.
- `field_sel` and `set_mode` change in the same cycle as the state; all outputs are registered.
- Repeat: pulse n≥1 occurs REPEAT_DELAY + (n-1)·REPEAT_RATE cycles after the initial pulse.

## Test plan
All scenarios use TICK_DIV=10, DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5, NUM_FIELDS=3.
- Free run, 35 cycles after reset → `en_s` high exactly in cycles 9, 19 and 29; `up`/`down`/`set_mode`/`field_sel` stay 0.
- `btn_mode` held high 12 cycles from cycle 3 → state change at cycle 10: `set_mode`=1, `field_sel`=3'b001, `en_s` stays 0. Three more presses give 3'b010, 3'b100, then RUN with `en_s` first high 9 cycles after the switch.
- A 3-cycle `btn_up` glitch in SET → no pulse. `btn_up` held 40 cycles → pulses at t0, t0+20, t0+25, t0+30, t0+35, each 1 cycle wide; none after release is debounced.
- `btn_up` and `btn_down` raised in the same cycle in SET → no pulses. `btn_down` held, then `btn_up` pressed → `down` repeats stop and no `up` pulse fires.
- Mode and up press events coincident in SET(0) → `field_sel`=3'b010 with no `up` pulse.
- `rst_n` low for 1 cycle mid-repeat in SET(1) with `btn_up` still held → next cycle: all outputs 0, RUN; an `up` press is debounced but yields no pulse (RUN).
